// File: rtl/wb_pkg.sv
// Shared types for the write-back commit stage: result-source select, FSM states,
// load funct3 encodings and the load legality check.
package wb_pkg;

    typedef enum logic [2:0] {
        WB_NONE  = 3'd0,
        WB_ALU   = 3'd1,
        WB_MEM   = 3'd2,
        WB_LINK  = 3'd3,
        WB_IMM   = 3'd4,
        WB_AUIPC = 3'd5,
        WB_SLT   = 3'd6
    } wb_sel_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } wb_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // A load is rejected when misaligned for its size, or when it asks for a
    // 64-bit-only form (LD/LWU) on a 32-bit datapath, or uses an unknown funct3.
    function automatic logic load_bad(input logic [2:0] funct3,
                                      input logic [2:0] addr_lo,
                                      input logic       xlen64);
        case (funct3)
            F3_LB, F3_LBU: return 1'b0;
            F3_LH, F3_LHU: return addr_lo[0];
            F3_LW:         return addr_lo[1:0] != 2'b00;
            F3_LWU:        return !xlen64 || (addr_lo[1:0] != 2'b00);
            F3_LD:         return !xlen64 || (addr_lo != 3'b000);
            default:       return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/wb_commit_stage_if.sv
// Bundle of the upstream instruction, data-memory response, register-file write
// and forwarding signals around the commit stage.
interface wb_commit_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_sel;
    logic [REG_AW-1:0] in_rd;
    logic [2:0]        in_funct3;
    logic [XLEN-1:0]   in_alu;
    logic [XLEN-1:0]   in_pc;
    logic [XLEN-1:0]   in_imm;
    logic              in_alu_neg;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_rd;
    logic [XLEN-1:0]   fwd_data;
    logic              busy;
    logic              err;

    modport master (
        output in_valid, in_sel, in_rd, in_funct3, in_alu, in_pc, in_imm, in_alu_neg,
        output mem_rvalid, mem_rdata,
        input  in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data, busy, err
    );

    modport slave (
        input  in_valid, in_sel, in_rd, in_funct3, in_alu, in_pc, in_imm, in_alu_neg,
        input  mem_rvalid, mem_rdata,
        output in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data, busy, err
    );

endinterface

// File: rtl/wb_load_extend.sv
// Combinational load formatter: picks the byte/half/word lane of the aligned
// memory word and sign- or zero-extends it to XLEN.
module wb_load_extend
    import wb_pkg::*;
#(
    parameter  int XLEN   = 32,
    localparam int LANE_W = $clog2(XLEN / 8)
) (
    input  logic [2:0]        i_funct3,
    input  logic [LANE_W-1:0] i_lane,
    input  logic [XLEN-1:0]   i_rdata,
    output logic [XLEN-1:0]   o_data
);

    logic [XLEN-1:0] w_shifted;

    assign w_shifted = i_rdata >> {i_lane, 3'b000};

    always_comb begin
        // NOTE: a default before the case gives every path a value, so no latch is inferred.
        o_data = '0;
        case (i_funct3)
            F3_LB:   o_data = XLEN'($signed(w_shifted[7:0]));
            F3_LH:   o_data = XLEN'($signed(w_shifted[15:0]));
            F3_LW:   o_data = XLEN'($signed(w_shifted[31:0]));
            F3_LBU:  o_data = XLEN'(w_shifted[7:0]);
            F3_LHU:  o_data = XLEN'(w_shifted[15:0]);
            F3_LWU:  o_data = XLEN'(w_shifted[31:0]);
            F3_LD:   o_data = i_rdata;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/wb_commit_stage.sv
// Registered write-back stage: builds the result of each retired instruction,
// waits for the memory response on loads, then commits one register-file write.
module wb_commit_stage
    import wb_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 255
) (
    input logic              clk,
    input logic              nRst,
    wb_commit_stage_if.slave bus
);

    localparam int   LANE_W = $clog2(XLEN / 8);
    localparam int   CNT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam logic XLEN64 = (XLEN == 64);

    wb_state_t         r_state,   w_state_nxt;
    logic [REG_AW-1:0] r_rd,      w_rd_nxt;
    logic [XLEN-1:0]   r_data,    w_data_nxt;
    logic [CNT_W-1:0]  r_cnt,     w_cnt_nxt;
    logic [2:0]        r_ld_f3,   w_ld_f3_nxt;
    logic [LANE_W-1:0] r_ld_lane, w_ld_lane_nxt;
    logic              r_err,     w_err_nxt;

    wb_sel_t           w_sel;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_ld_bad;
    logic              w_has_result;
    logic [XLEN-1:0]   w_result;
    logic [XLEN-1:0]   w_load_data;

    assign w_sel      = wb_sel_t'(bus.in_sel);
    assign w_in_ready = (r_state == IDLE) || (r_state == COMMIT);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_ld_bad   = load_bad(bus.in_funct3, bus.in_alu[2:0], XLEN64);

    // Non-load result sources; WB_NONE and reserved encodings retire without a write.
    always_comb begin
        w_result     = '0;
        w_has_result = 1'b1;
        case (w_sel)
            WB_ALU:   w_result = bus.in_alu;
            WB_LINK:  w_result = bus.in_pc + XLEN'(4);
            WB_IMM:   w_result = bus.in_imm;
            WB_AUIPC: w_result = bus.in_pc + bus.in_imm;
            WB_SLT:   w_result = XLEN'(bus.in_alu_neg);
            default:  w_has_result = 1'b0;
        endcase
    end

    wb_load_extend #(
        .XLEN(XLEN)
    ) u_load_extend (
        .i_funct3(r_ld_f3),
        .i_lane  (r_ld_lane),
        .i_rdata (bus.mem_rdata),
        .o_data  (w_load_data)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_rd_nxt      = r_rd;
        w_data_nxt    = r_data;
        w_cnt_nxt     = r_cnt;
        w_ld_f3_nxt   = r_ld_f3;
        w_ld_lane_nxt = r_ld_lane;
        w_err_nxt     = 1'b0;

        case (r_state)
            WAIT_MEM: begin
                // A response on the last allowed cycle still wins over the timeout.
                if (bus.mem_rvalid) begin
                    w_state_nxt = COMMIT;
                    w_data_nxt  = w_load_data;
                end else if (r_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                    w_state_nxt = IDLE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                if (w_accept) begin
                    if (w_sel == WB_MEM) begin
                        if (w_ld_bad) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_state_nxt   = WAIT_MEM;
                            w_rd_nxt      = bus.in_rd;
                            w_cnt_nxt     = '0;
                            w_ld_f3_nxt   = bus.in_funct3;
                            w_ld_lane_nxt = bus.in_alu[LANE_W-1:0];
                        end
                    end else if (w_has_result) begin
                        w_state_nxt = COMMIT;
                        w_rd_nxt    = bus.in_rd;
                        w_data_nxt  = w_result;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            // NOTE: datapath registers are reset too, so the write and bypass buses read 0 out of reset.
            r_state   <= IDLE;
            r_rd      <= '0;
            r_data    <= '0;
            r_cnt     <= '0;
            r_ld_f3   <= '0;
            r_ld_lane <= '0;
            r_err     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state   <= w_state_nxt;
            r_rd      <= w_rd_nxt;
            r_data    <= w_data_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ld_f3   <= w_ld_f3_nxt;
            r_ld_lane <= w_ld_lane_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // x0 is never written nor offered for bypass; in WAIT_MEM the bypass data is not yet valid.
    assign bus.in_ready  = w_in_ready;
    assign bus.rf_we     = (r_state == COMMIT) && (r_rd != '0);
    assign bus.rf_waddr  = r_rd;
    assign bus.rf_wdata  = r_data;
    assign bus.fwd_valid = (r_state != IDLE) && (r_rd != '0);
    assign bus.fwd_rd    = r_rd;
    assign bus.fwd_data  = r_data;
    assign bus.busy      = (r_state != IDLE);
    assign bus.err       = r_err;

endmodule

// File: tb/tb_wb_commit_stage.sv
// Scoreboard bench for wb_commit_stage: the driver predicts each write/err event
// with a behavioural model and queues it; a monitor pops and compares on output.
module tb_wb_commit_stage;
    import wb_pkg::*;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int TMO    = 4;

    typedef struct {
        wb_sel_t     sel;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        neg;
        logic [31:0] rdata;
        int          k;
    } txn_t;

    typedef struct {
        bit          is_err;
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic clk  = 1'b0;
    logic nRst = 1'b0;
    int   cyc  = 0;
    int   n_checks = 0;
    int   n_errs   = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wb_commit_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

    wb_commit_stage #(
        .XLEN(XLEN), .REG_AW(REG_AW), .MEM_TIMEOUT(TMO)
    ) dut (
        .clk (clk),
        .nRst(nRst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: results straight from the instruction semantics.
    function automatic logic [31:0] model_result(input txn_t t);
        case (t.sel)
            WB_ALU:   return t.alu;
            WB_LINK:  return t.pc + 32'd4;
            WB_IMM:   return t.imm;
            WB_AUIPC: return t.pc + t.imm;
            WB_SLT:   return t.neg ? 32'd1 : 32'd0;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic int load_size(input logic [2:0] f3);
        case (f3)
            F3_LH, F3_LHU: return 2;
            F3_LW:         return 4;
            default:       return 1;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int          off;
        int          sz;
        logic [31:0] v;
        bit          sgn;
        off = int'(addr % 4);
        sz  = load_size(f3);
        sgn = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW);
        v   = rdata >> (8 * off);
        if (sz == 1) begin
            v = v & 32'hFF;
            if (sgn && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (sgn && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    function automatic txn_t mk(input wb_sel_t sel, input logic [4:0] rd, input logic [2:0] f3,
                                input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] imm,
                                input logic neg, input logic [31:0] rdata, input int k);
        txn_t t;
        t.sel = sel; t.rd = rd; t.f3 = f3; t.alu = alu; t.pc = pc; t.imm = imm;
        t.neg = neg; t.rdata = rdata; t.k = k;
        return t;
    endfunction

    // Issue one instruction (called at posedge+1); for aligned loads also play the
    // memory: respond in WAIT_MEM cycle k, or never when k exceeds the timeout.
    task automatic send(input txn_t t, output int acc_cyc);
        bit   ok;
        int   waited;
        exp_t e;
        ok      = 1'b0;
        waited  = 0;
        acc_cyc = -1;
        bus.in_valid   = 1'b1;
        bus.in_sel     = t.sel;
        bus.in_rd      = t.rd;
        bus.in_funct3  = t.f3;
        bus.in_alu     = t.alu;
        bus.in_pc      = t.pc;
        bus.in_imm     = t.imm;
        bus.in_alu_neg = t.neg;
        while (!ok && waited < 50) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok      = 1'b1;
                acc_cyc = cyc;
            end
            step();
            waited++;
        end
        bus.in_valid = 1'b0;
        check("accepted", ok, 1);
        if (!ok) return;

        e.rd = t.rd;
        if (t.sel == WB_MEM) begin
            if ((t.alu % load_size(t.f3)) != 0) begin
                e.is_err = 1'b1; e.cyc = acc_cyc + 1; e.data = 32'd0;
                exp_q.push_back(e);
            end else if (t.k <= TMO) begin
                if (t.rd != 5'd0) begin
                    e.is_err = 1'b0; e.cyc = acc_cyc + t.k + 1;
                    e.data = model_load(t.f3, t.alu, t.rdata);
                    exp_q.push_back(e);
                end
                repeat (t.k - 1) step();
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = t.rdata;
                step();
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = $urandom;
            end else begin
                e.is_err = 1'b1; e.cyc = acc_cyc + TMO + 1; e.data = 32'd0;
                exp_q.push_back(e);
                repeat (TMO) step();
            end
        end else if (t.rd != 5'd0) begin
            e.is_err = 1'b0; e.cyc = acc_cyc + 1; e.data = model_result(t);
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (nRst && (bus.rf_we || bus.err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {bus.rf_we, bus.err}, 2'b00);
            end else begin
                e = exp_q.pop_front();
                check("event_kind_err", bus.err, e.is_err);
                check("event_cycle", cyc, e.cyc);
                if (!e.is_err) begin
                    check("rf_waddr", bus.rf_waddr, e.rd);
                    check("rf_wdata", bus.rf_wdata, e.data);
                    check("fwd_bus", {bus.fwd_valid, bus.fwd_rd, bus.fwd_data}, {1'b1, e.rd, e.data});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int       c1, c2;
        txn_t     t;
        wb_sel_t  sels[6];
        logic [2:0] f3s[5];
        sels = '{WB_ALU, WB_MEM, WB_LINK, WB_IMM, WB_AUIPC, WB_SLT};
        f3s  = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};

        bus.in_valid = 1'b0; bus.in_sel = '0; bus.in_rd = '0; bus.in_funct3 = '0;
        bus.in_alu = '0; bus.in_pc = '0; bus.in_imm = '0; bus.in_alu_neg = 1'b0;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {bus.rf_we, bus.fwd_valid, bus.busy, bus.err}, 4'b0000);
        check("reset_wr", {bus.rf_waddr, bus.rf_wdata}, '0);
        check("reset_fwd", {bus.fwd_rd, bus.fwd_data}, '0);
        @(negedge clk);
        nRst = 1'b1;
        check("reset_ready", bus.in_ready, 1);
        step();

        // Back-to-back ALU results
        send(mk(WB_ALU, 5'd5, F3_LW, 32'h11, 32'h0, 32'h0, 1'b0, 32'h0, 1), c1);
        send(mk(WB_ALU, 5'd6, F3_LW, 32'h22, 32'h0, 32'h0, 1'b0, 32'h0, 1), c2);
        check("b2b_accept_gap", c2 - c1, 1);

        // Sign/zero-extended byte loads from lane 3
        send(mk(WB_MEM, 5'd10, F3_LB,  32'h1003, 32'h0, 32'h0, 1'b0, 32'h80FF_FF12, 3), c1);
        send(mk(WB_MEM, 5'd11, F3_LBU, 32'h1003, 32'h0, 32'h0, 1'b0, 32'h80FF_FF12, 3), c1);

        // Misaligned half-word: err only, never busy
        send(mk(WB_MEM, 5'd12, F3_LH, 32'h1001, 32'h0, 32'h0, 1'b0, 32'h0, 1), c1);
        @(negedge clk);
        check("misaligned_busy", bus.busy, 0);
        check("misaligned_ready", bus.in_ready, 1);
        step();

        // Timeout, then response on the last allowed cycle
        send(mk(WB_MEM, 5'd13, F3_LW, 32'h2000, 32'h0, 32'h0, 1'b0, 32'hCAFE_0001, TMO + 1), c1);
        send(mk(WB_MEM, 5'd14, F3_LW, 32'h2004, 32'h0, 32'h0, 1'b0, 32'hCAFE_0002, TMO), c1);

        // Link wrap, AUIPC, SLT, and an x0 destination
        send(mk(WB_LINK,  5'd7, F3_LW, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0, 1), c1);
        send(mk(WB_AUIPC, 5'd8, F3_LW, 32'h0, 32'h1000, 32'h2000_0000, 1'b0, 32'h0, 1), c1);
        send(mk(WB_SLT,   5'd9, F3_LW, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 1), c1);
        send(mk(WB_ALU,   5'd0, F3_LW, 32'hDEAD, 32'h0, 32'h0, 1'b0, 32'h0, 1), c1);
        @(negedge clk);
        check("x0_no_write_fwd", {bus.rf_we, bus.fwd_valid}, 2'b00);
        step();
        repeat (3) step();

        // Reset in the middle of WAIT_MEM, then a late response
        bus.in_valid = 1'b1; bus.in_sel = WB_MEM; bus.in_funct3 = F3_LW;
        bus.in_alu = 32'h3000; bus.in_rd = 5'd9;
        @(negedge clk);
        check("rst_pre_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("wait_mem_hazard", {bus.fwd_valid, bus.busy, bus.rf_we, bus.fwd_rd}, {1'b1, 1'b1, 1'b0, 5'd9});
        #2 nRst = 1'b0;
        #1;
        check("midrst_ctrl", {bus.rf_we, bus.fwd_valid, bus.busy, bus.err}, 4'b0000);
        check("midrst_wr", {bus.rf_waddr, bus.rf_wdata}, '0);
        check("midrst_fwd", {bus.fwd_rd, bus.fwd_data}, '0);
        step();
        nRst = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1234_5678;
        step();
        bus.mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_rvalid_ignored", {bus.rf_we, bus.busy, bus.err}, 3'b000);
        end
        step();

        // Randomized traffic with idle gaps and stray memory responses
        for (int n = 0; n < 300; n++) begin
            t.sel   = sels[$urandom_range(0, 5)];
            t.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            t.f3    = f3s[$urandom_range(0, 4)];
            t.alu   = $urandom;
            t.pc    = $urandom;
            t.imm   = $urandom;
            t.neg   = 1'($urandom_range(0, 1));
            t.rdata = $urandom;
            t.k     = $urandom_range(1, TMO + 1);
            send(t, c1);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                if ($urandom_range(0, 1) == 1) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = $urandom;
                end
                step();
                bus.mem_rvalid = 1'b0;
            end
        end

        repeat (TMO + 4) step();
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
